// File: rtl/tag_op_stim_gen.sv
// Stimulus source for non-blocking cache tag-op regressions.
// Walks every (way, set) pair three times issuing TAGST, TAGLV, then TAGLA.
// Each request carries a unique non-zero id. A credit count bounds the number
// of responses in flight. done_o rises once every response has come back.
module tag_op_stim_gen #(
  parameter int src_id_width_p        = 8,
  parameter int data_width_p          = 32,
  parameter int addr_width_p          = 32,
  parameter int ways_p                = 2,
  parameter int sets_p                = 4,
  parameter int tag_width_lp          = 20,
  parameter int block_size_in_words_p = 8,
  parameter int max_out_p             = 4,
  parameter int seed_p                = 'h5A5,
  localparam int block_offset_width_lp = $clog2(data_width_p >> 3) + $clog2(block_size_in_words_p),
  localparam int lg_ways_lp            = $clog2(ways_p),
  localparam int lg_sets_lp            = $clog2(sets_p),
  localparam int opcode_width_lp       = 6,
  localparam int mask_width_lp         = data_width_p >> 3,
  localparam int bsg_cache_nb_pkt_width_lp =
    opcode_width_lp + src_id_width_p + addr_width_p + data_width_p + mask_width_lp
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  output logic                                 v_o,
  output logic [bsg_cache_nb_pkt_width_lp-1:0] cache_pkt_o,
  input  logic                                 yumi_i,
  input  logic                                 v_i,
  input  logic [src_id_width_p-1:0]            src_id_i,
  output logic                                 yumi_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int cnt_w_lp = lg_ways_lp + lg_sets_lp;
  localparam int out_w_lp = $clog2(max_out_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(ways_p * sets_p - 1);

  // Tag-op opcode encodings of the cache packet.
  localparam logic [opcode_width_lp-1:0] op_tagst_lp = 6'b010000;
  localparam logic [opcode_width_lp-1:0] op_taglv_lp = 6'b010010;
  localparam logic [opcode_width_lp-1:0] op_tagla_lp = 6'b010011;

  typedef enum logic [2:0] {IDLE, STORE, LOAD_V, LOAD_A, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
  logic [src_id_width_p-1:0] next_id_q, next_id_d;
  logic [out_w_lp-1:0]       out_q, out_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                       issuing;
  logic                       req_acc;
  logic [opcode_width_lp-1:0] pkt_op;
  logic [addr_width_p-1:0]    pkt_addr;
  logic [data_width_p-1:0]    pkt_data;

  // Handshakes: issue only while walking and a credit is free; accept responses once started.
  always_comb begin
    issuing = (state_q == STORE) || (state_q == LOAD_V) || (state_q == LOAD_A);
    v_o     = issuing && (out_q < out_w_lp'(max_out_p));
    req_acc = v_o && yumi_i;
    yumi_o  = v_i && (state_q != IDLE);
  end

  // Request packet built purely from registers so it holds steady while stalled.
  always_comb begin
    pkt_op   = '0;
    pkt_addr = '0;
    pkt_data = '0;
    pkt_addr[block_offset_width_lp + lg_sets_lp +: lg_ways_lp] = cnt_q[cnt_w_lp-1 -: lg_ways_lp];
    pkt_addr[block_offset_width_lp +: lg_sets_lp]              = cnt_q[lg_sets_lp-1:0];
    case (state_q)
      STORE: begin
        pkt_op = op_tagst_lp;
        pkt_data[tag_width_lp-1:0] = tag_width_lp'(seed_p) ^ tag_width_lp'(cnt_q);
        pkt_data[data_width_p-1]   = 1'b1;
        pkt_data[data_width_p-2]   = cnt_q[0];
      end
      LOAD_V:  pkt_op = op_taglv_lp;
      LOAD_A:  pkt_op = op_tagla_lp;
      default: pkt_op = '0;
    endcase
    cache_pkt_o = '0;
    if (v_o) begin
      cache_pkt_o = {pkt_op, next_id_q, pkt_addr, pkt_data, {mask_width_lp{1'b1}}};
    end
  end

  // Next-state: walk counter, id generator, credit tracking and error capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    next_id_d = next_id_q;
    out_d     = out_q;
    err_d     = err_q;
    done_d    = done_q || (state_q == DONE);

    if (req_acc) begin
      // Id 0 is reserved as "no id", so a wrap skips straight to 1.
      next_id_d = (next_id_q == '1) ? src_id_width_p'(1) : next_id_q + src_id_width_p'(1);
      if (cnt_q == cnt_last_lp) begin
        cnt_d = '0;
        case (state_q)
          STORE:   state_d = LOAD_V;
          LOAD_V:  state_d = LOAD_A;
          default: state_d = DRAIN;
        endcase
      end else begin
        cnt_d = cnt_q + cnt_w_lp'(1);
      end
    end

    case (state_q)
      IDLE:    if (start_i) state_d = STORE;
      DRAIN:   if (out_q == '0) state_d = DONE;
      default: ;
    endcase

    if (yumi_o && ((out_q == '0) || (src_id_i == '0))) begin
      err_d = 1'b1;
    end

    // A response with nothing outstanding retires nothing, so the count never underflows.
    case ({req_acc, yumi_o})
      2'b10:   out_d = out_q + out_w_lp'(1);
      2'b01:   if (out_q != '0) out_d = out_q - out_w_lp'(1);
      2'b11:   if (out_q == '0) out_d = out_q + out_w_lp'(1);
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      next_id_q <= src_id_width_p'(1);
      out_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      next_id_q <= next_id_d;
      out_q     <= out_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_tag_op_stim_gen.sv
// Directed bench for tag_op_stim_gen: expected request packets are queued when
// the sequence is started and popped as the DUT's requests are accepted.
module tb_tag_op_stim_gen;

  localparam int PW   = 82;
  localparam int NREQ = 24;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          reset_i, start_i, yumi_i, v_i;
  logic [7:0]    src_id_i;
  logic          v_o, yumi_o, done_o, err_o;
  logic [PW-1:0] cache_pkt_o;

  always #5 clk = ~clk;

  tag_op_stim_gen dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .v_o         (v_o),
    .cache_pkt_o (cache_pkt_o),
    .yumi_i      (yumi_i),
    .v_i         (v_i),
    .src_id_i    (src_id_i),
    .yumi_o      (yumi_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  int            resp_id_q[$];
  int            resp_t_q[$];
  int            cyc = 0;
  int            out_m = 0;
  int            issued_m = 0;
  int            both_cnt = 0;
  bit            running = 0;
  bit            rst_req = 0;
  bit            start_req = 0;
  bit            yumi_en = 1;
  bit            resp_en = 1;
  bit            inj_v = 0;
  logic [7:0]    inj_id = '0;
  int            stall_id = 0;
  int            stall_left = 0;
  bit            stall_seen = 0;
  logic [PW-1:0] stall_pkt;
  logic [PW-1:0] log_pkt [0:255];
  int            acc_cnt [0:255];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference packet for the k-th request (0-based) with default parameters.
  function automatic logic [PW-1:0] exp_pkt(input int k);
    int pass, c, way, st;
    logic [5:0]  op;
    logic [31:0] addr, data;
    pass = k / 8;
    c    = k % 8;
    way  = c / 4;
    st   = c % 4;
    addr = (32'(way) << 7) | (32'(st) << 5);
    data = 32'h0;
    case (pass)
      0: begin
        op   = 6'h10;
        data = 32'h8000_0000 | (32'(c % 2) << 30) | ((32'h5A5 ^ 32'(c)) & 32'h000F_FFFF);
      end
      1:       op = 6'h12;
      default: op = 6'h13;
    endcase
    return {op, 8'(k + 1), addr, data, 4'hF};
  endfunction

  task automatic flush();
    exp_q.delete();
    resp_id_q.delete();
    resp_t_q.delete();
    out_m = 0;
    issued_m = 0;
    both_cnt = 0;
    running = 0;
    stall_left = 0;
    stall_seen = 0;
    inj_v = 0;
    for (int i = 0; i < 256; i++) begin
      log_pkt[i] = '0;
      acc_cnt[i] = 0;
    end
  endtask

  task automatic load();
    for (int k = 0; k < NREQ; k++) exp_q.push_back(exp_pkt(k));
  endtask

  // One clock: inputs driven on the falling edge, outputs sampled 1 time unit later.
  task automatic tick();
    logic          acc, rsp;
    logic [PW-1:0] got;
    @(negedge clk);
    cyc++;
    chk("v_o", v_o, (running && issued_m < NREQ && out_m < MAXO));
    reset_i   = rst_req;
    start_i   = start_req;
    start_req = 0;
    yumi_i    = 1'b0;
    v_i       = 1'b0;
    src_id_i  = '0;
    if (!reset_i) begin
      if (v_o === 1'b1 && yumi_en) begin
        if (stall_left > 0 && int'(cache_pkt_o[75:68]) == stall_id) begin
          if (stall_seen) chk("stall_stable", cache_pkt_o, stall_pkt);
          else begin
            stall_pkt  = cache_pkt_o;
            stall_seen = 1;
          end
          stall_left--;
        end else begin
          yumi_i = 1'b1;
        end
      end
      if (inj_v) begin
        v_i      = 1'b1;
        src_id_i = inj_id;
        inj_v    = 0;
      end else if (resp_id_q.size() > 0 && resp_t_q[0] <= cyc) begin
        v_i      = 1'b1;
        src_id_i = 8'(resp_id_q.pop_front());
        void'(resp_t_q.pop_front());
      end
    end
    #1;
    chk("yumi_o", yumi_o, (v_i && running));
    acc = yumi_i;
    rsp = v_i && running;
    if (acc) begin
      got = cache_pkt_o;
      chk("sb_nonempty", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) chk("req_pkt", got, exp_q.pop_front());
      log_pkt[got[75:68]] = got;
      acc_cnt[got[75:68]]++;
      issued_m++;
      if (resp_en) begin
        resp_id_q.push_back(int'(got[75:68]));
        resp_t_q.push_back(cyc + 2);
      end
    end
    if (acc && rsp) both_cnt++;
    if (rsp) out_m = (out_m > 0) ? out_m - 1 + int'(acc) : int'(acc);
    else     out_m = out_m + int'(acc);
    if (start_i) running = 1;
    if (reset_i) flush();
  endtask

  task automatic do_reset();
    rst_req = 1;
    tick();
    rst_req = 0;
  endtask

  task automatic run_until_done(input int bound, input string tag);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done_o, 1'b1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v_o"}, v_o, 1'b0);
    chk({tag, "_yumi_o"}, yumi_o, 1'b0);
    chk({tag, "_done_o"}, done_o, 1'b0);
    chk({tag, "_err_o"}, err_o, 1'b0);
    chk({tag, "_pkt"}, cache_pkt_o, '0);
  endtask

  initial begin
    int n, once;
    reset_i  = 1'b1;
    start_i  = 1'b0;
    yumi_i   = 1'b0;
    v_i      = 1'b0;
    src_id_i = '0;
    flush();

    // Reset state; a response while idle must be ignored.
    do_reset();
    inj_v  = 1;
    inj_id = 8'h07;
    tick();
    chk_idle("rst");

    // Full sequence, responses two cycles after acceptance.
    do_reset();
    load();
    start_req = 1;
    run_until_done(400, "main");
    chk("main_err", err_o, 1'b0);
    chk("main_issued", issued_m, NREQ);
    chk("main_sb_empty", exp_q.size(), 0);
    once = 0;
    for (int i = 1; i <= NREQ; i++) if (acc_cnt[i] == 1) once++;
    chk("main_ids_once", once, NREQ);
    chk("main_both_seen", (both_cnt > 0), 1'b1);
    chk("main_id1", log_pkt[1], {6'h10, 8'd1, 32'h0000_0000, 32'h8000_05A5, 4'hF});
    chk("main_id2", log_pkt[2], {6'h10, 8'd2, 32'h0000_0020, 32'hC000_05A4, 4'hF});
    chk("main_id5", log_pkt[5], {6'h10, 8'd5, 32'h0000_0080, 32'h8000_05A1, 4'hF});
    chk("main_id6", log_pkt[6], {6'h10, 8'd6, 32'h0000_00A0, 32'hC000_05A0, 4'hF});
    chk("main_id10", log_pkt[10], {6'h12, 8'd10, 32'h0000_0020, 32'h0, 4'hF});
    chk("main_id14", log_pkt[14], {6'h12, 8'd14, 32'h0000_00A0, 32'h0, 4'hF});
    chk("main_id24", log_pkt[24], {6'h13, 8'd24, 32'h0000_00E0, 32'h0, 4'hF});
    repeat (3) tick();
    chk("main_done_held", done_o, 1'b1);

    // Credit limit: no responses, then a single one.
    do_reset();
    load();
    resp_en   = 0;
    start_req = 1;
    repeat (30) tick();
    chk("credit_issued", issued_m, MAXO);
    chk("credit_v_o", v_o, 1'b0);
    inj_v  = 1;
    inj_id = 8'd1;
    tick();
    repeat (10) tick();
    chk("credit_one_more", issued_m, MAXO + 1);
    chk("credit_v_o_again", v_o, 1'b0);
    resp_en = 1;

    // Backpressure: id 3 held for five cycles.
    do_reset();
    load();
    stall_id   = 3;
    stall_left = 5;
    start_req  = 1;
    run_until_done(400, "bp");
    chk("bp_stall_used", stall_left, 0);
    chk("bp_id3_once", acc_cnt[3], 1);
    chk("bp_issued", issued_m, NREQ);
    chk("bp_err", err_o, 1'b0);

    // Spurious response with nothing outstanding.
    do_reset();
    load();
    yumi_en   = 0;
    start_req = 1;
    tick();
    tick();
    chk("spur_err_pre", err_o, 1'b0);
    inj_v  = 1;
    inj_id = 8'd5;
    tick();
    tick();
    chk("spur_err_set", err_o, 1'b1);
    yumi_en = 1;
    run_until_done(400, "spur");
    chk("spur_err_sticky", err_o, 1'b1);

    // Response carrying id 0 while requests are outstanding.
    do_reset();
    load();
    start_req = 1;
    n = 0;
    while (out_m < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("sid0_err_pre", err_o, 1'b0);
    inj_v  = 1;
    inj_id = 8'd0;
    tick();
    tick();
    chk("sid0_err_set", err_o, 1'b1);
    run_until_done(400, "sid0");

    // Reset in the middle of the TAGLV pass, then restart.
    do_reset();
    load();
    start_req = 1;
    n = 0;
    while (issued_m < 11 && n < 200) begin
      tick();
      n++;
    end
    chk("midrst_reached", issued_m, 11);
    do_reset();
    inj_v  = 1;
    inj_id = 8'd4;
    tick();
    chk_idle("midrst");
    load();
    start_req = 1;
    run_until_done(400, "restart");
    chk("restart_id1", log_pkt[1], {6'h10, 8'd1, 32'h0000_0000, 32'h8000_05A5, 4'hF});
    chk("restart_issued", issued_m, NREQ);
    chk("restart_err", err_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
